// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA control AXI4-Lite slave: register indices,
// response codes, output field layout and the byte-strobe merge helper.
package vga_ctrl_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_BG_COLOR = 2'd1;
  localparam logic [1:0] REG_POS      = 2'd2;
  localparam logic [1:0] REG_SCRATCH  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int ENABLE_BIT = 0;
  localparam int RGB_LSB    = 0;
  localparam int RGB_W      = 12;
  localparam int XPOS_LSB   = 0;
  localparam int XPOS_W     = 11;
  localparam int YPOS_LSB   = 16;
  localparam int YPOS_W     = 10;

  typedef struct packed {
    logic              enable;
    logic [RGB_W-1:0]  rgb;
    logic [XPOS_W-1:0] xpos;
    logic [YPOS_W-1:0] ypos;
  } vga_out_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_ctrl_regfile.sv
// 4x32 control register storage: byte-strobe write port, async read port and
// the VGA output fields, optionally frame-latched when VGA_CTRL_SHADOW_EN is defined.
import vga_ctrl_pkg::*;

module vga_ctrl_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [1:0]  rd_idx,
  output logic [31:0] rd_data,
  input  logic        vsync_i,
  output vga_out_t    out_o
);

  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  vga_out_t    live;

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[wr_idx] = merge_bytes(regs_q[wr_idx], wr_data, wr_strb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Reads see the stored value, so a read captured alongside a commit gets the old word.
  assign rd_data = regs_q[rd_idx];

  always_comb begin
    live.enable = regs_q[REG_CTRL][ENABLE_BIT];
    live.rgb    = regs_q[REG_BG_COLOR][RGB_LSB +: RGB_W];
    live.xpos   = regs_q[REG_POS][XPOS_LSB +: XPOS_W];
    live.ypos   = regs_q[REG_POS][YPOS_LSB +: YPOS_W];
  end

`ifdef VGA_CTRL_SHADOW_EN
  vga_out_t shadow_q;
  vga_out_t shadow_d;

  // Snapshot the pre-edge registers, so a same-cycle write waits for the next frame.
  always_comb begin
    shadow_d = shadow_q;
    if (vsync_i) shadow_d = live;
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign out_o = shadow_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync_i;
  assign out_o        = live;
`endif

endmodule

// File: rtl/vga_ctrl_axil_slave.sv
// AXI4-Lite slave for VGA control registers; write commits 1 cycle after AW+W, B next; read data 1 cycle after AR.
// Backpressure: one write and one read outstanding, B/R held until READY. VGA_CTRL_SHADOW_EN frame-latches outputs.
import vga_ctrl_pkg::*;

module vga_ctrl_axil_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  input  logic                    vsync_i,
  output logic                    enable_o,
  output logic [11:0]             bg_rgb_o,
  output logic [10:0]             xpos_o,
  output logic [9:0]              ypos_o
);

  logic        aw_full_q, aw_full_d;
  logic [1:0]  aw_idx_q, aw_idx_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs, commit, b_done;
  logic [31:0] rf_rd_data;
  vga_out_t    rf_out;

  // Readies are gated by reset so nothing is accepted while ARESET is high.
  always_comb begin
    awready = ~ARESET & ~aw_full_q & ~bvalid_q;
    wready  = ~ARESET & ~w_full_q & ~bvalid_q;
    arready = ~ARESET & ~rvalid_q;
    aw_hs   = AWVALID & awready;
    w_hs    = WVALID & wready;
    ar_hs   = ARVALID & arready;
    commit  = aw_full_q & w_full_q & ~bvalid_q;
    b_done  = bvalid_q & BREADY;
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (b_done) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = AWADDR[3:2];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = WDATA;
        w_strb_d = WSTRB;
      end
    end
    bvalid_d = bvalid_q ? ~BREADY : commit;
  end

  always_comb begin
    rvalid_d = rvalid_q ? ~RREADY : ar_hs;
    rdata_d  = ar_hs ? rf_rd_data : rdata_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  vga_ctrl_regfile u_regfile (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (commit),
    .wr_idx  (aw_idx_q),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q),
    .rd_idx  (ARADDR[3:2]),
    .rd_data (rf_rd_data),
    .vsync_i (vsync_i),
    .out_o   (rf_out)
  );

  assign AWREADY  = awready;
  assign WREADY   = wready;
  assign ARREADY  = arready;
  assign BVALID   = bvalid_q;
  assign BRESP    = RESP_OKAY;
  assign RVALID   = rvalid_q;
  assign RRESP    = RESP_OKAY;
  assign RDATA    = rdata_q;
  assign enable_o = rf_out.enable;
  assign bg_rgb_o = rf_out.rgb;
  assign xpos_o   = rf_out.xpos;
  assign ypos_o   = rf_out.ypos;

  logic unused_axi;
  assign unused_axi = ^{AWPROT, ARPROT, AWADDR, ARADDR};

endmodule
